// File: rtl/regfile_write_arbiter_if.sv
// Writeback request bus shared by the two requesters of the register file
// write port. Each requester presents valid/addr/data and holds them stable
// until the arbiter answers with a one-cycle ready.
interface regfile_write_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
);

    // requester 0: ALU result path
    logic              req0_valid;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_data;
    logic              req0_ready;

    // requester 1: load / memory-return path
    logic              req1_valid;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_data;
    logic              req1_ready;

    // requester side: drives requests, observes acceptance
    modport master (
        output req0_valid, req0_addr, req0_data,
        input  req0_ready,
        output req1_valid, req1_addr, req1_data,
        input  req1_ready
    );

    // arbiter side: observes requests, returns acceptance
    modport slave (
        input  req0_valid, req0_addr, req0_data,
        output req0_ready,
        input  req1_valid, req1_addr, req1_data,
        output req1_ready
    );

endinterface

// File: rtl/regfile_write_arbiter.sv
// Owner of the register file write port (WE3/A3/WD3).
// After reset it sweeps zeros into every writable register, then shares the
// port round-robin between the ALU and load writeback paths. Writes aimed at
// addresses outside the writable range (R15 is the PC) are accepted and
// discarded, flagged by a one-cycle drop_pulse.
module regfile_write_arbiter #(
    parameter int          DATA_W   = 32,
    parameter int          ADDR_W   = 4,
    parameter int unsigned NUM_REGS = 15
) (
    input  logic                  CLK,
    input  logic                  reset_n,
    regfile_write_arbiter_if.slave req,
    output logic                  WE3,
    output logic [ADDR_W-1:0]     A3,
    output logic [DATA_W-1:0]     WD3,
    output logic                  init_busy,
    output logic                  drop_pulse
);

    // Two-state controller: clear sweep, then normal arbitration.
    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Address written by the last edge of the clear sweep.
    localparam logic [ADDR_W-1:0] LAST_CLR = ADDR_W'(NUM_REGS - 1);

    logic [0:0]        state;
    logic [ADDR_W-1:0] clr_cnt;
    logic              rr_ptr;     // requester favoured when both are valid

    logic              grant0;
    logic              grant1;
    logic              grant_any;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic              sel_in_range;
    logic              last_clr;

    // Grant decision: a lone requester always wins; on contention rr_ptr decides.
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == ST_RUN) begin
            if (req.req0_valid && req.req1_valid) begin
                grant0 = ~rr_ptr;
                grant1 = rr_ptr;
            end else begin
                grant0 = req.req0_valid;
                grant1 = req.req1_valid;
            end
        end
    end

    assign req.req0_ready = grant0;
    assign req.req1_ready = grant1;

    // Winner's payload and whether its destination is a writable register.
    always_comb begin
        grant_any    = grant0 | grant1;
        sel_addr     = grant1 ? req.req1_addr : req.req0_addr;
        sel_data     = grant1 ? req.req1_data : req.req0_data;
        sel_in_range = (32'(sel_addr) < NUM_REGS);
    end

    assign last_clr  = (clr_cnt == LAST_CLR);
    assign init_busy = (state == ST_INIT);

    // Controller state: sweep counter, INIT->RUN transition, round-robin pointer.
    // NOTE: sequential state uses non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_INIT;
            clr_cnt <= '0;
            rr_ptr  <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    clr_cnt <= clr_cnt + ADDR_W'(1);
                    if (last_clr) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // The requester just served loses priority on the next contention.
                    if (grant_any) begin
                        rr_ptr <= ~grant1;
                    end
                end
                default: begin
                    state <= ST_INIT;
                end
            endcase
        end
    end

    // Registered write port: zero sweep in INIT, granted write (or drop) in RUN.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            WE3        <= 1'b0;
            A3         <= '0;
            WD3        <= '0;
            drop_pulse <= 1'b0;
        end else if (state == ST_INIT) begin
            WE3        <= 1'b1;
            A3         <= clr_cnt;
            WD3        <= '0;
            drop_pulse <= 1'b0;
        end else begin
            // A3/WD3 keep their last value on idle or dropped cycles.
            WE3        <= 1'b0;
            drop_pulse <= 1'b0;
            if (grant_any) begin
                if (sel_in_range) begin
                    WE3 <= 1'b1;
                    A3  <= sel_addr;
                    WD3 <= sel_data;
                end else begin
                    drop_pulse <= 1'b1;
                end
            end
        end
    end

    // The PC register (and anything beyond the writable range) is never written.
    a_no_write_out_of_range: assert property (
        @(posedge CLK) disable iff (!reset_n) WE3 |-> (32'(A3) < NUM_REGS)
    );

    // At most one requester is accepted per cycle.
    a_single_grant: assert property (
        @(posedge CLK) disable iff (!reset_n) !(req.req0_ready && req.req1_ready)
    );

    // Nothing is accepted while the clear sweep is still running.
    a_no_grant_in_init: assert property (
        @(posedge CLK) disable iff (!reset_n) init_busy |-> !(req.req0_ready || req.req1_ready)
    );

endmodule
